// File: rtl/ft2232_fifo_arbiter.sv
// FT2232H synchronous-FIFO bus arbiter: time-shares the half-duplex bus between RX and TX bursts.
// Optional SIWU flush after TX bursts is enabled by defining FIFO_SIWU_FLUSH_EN.
module ft2232_fifo_arbiter #(
    parameter int RX_BUF_DEPTH = 8,
    parameter int MAX_BURST    = 64,
    parameter int SIWU_IDLE    = 16
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       fifo_rxf_n_i,
    input  logic       fifo_txe_n_i,
    input  logic [7:0] fifo_data_i,
    output logic [7:0] fifo_data_o,
    output logic       fifo_data_oe_o,
    output logic       fifo_oe_n_o,
    output logic       fifo_rd_n_o,
    output logic       fifo_wr_n_o,
    output logic       fifo_siwu_o,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    input  logic       rx_ready_i,
    input  logic [7:0] tx_data_i,
    input  logic       tx_valid_i,
    output logic       tx_ready_o
);

    localparam int          AW          = $clog2(RX_BUF_DEPTH);
    localparam logic [AW:0] DEPTH_C     = (AW + 1)'(RX_BUF_DEPTH);
    localparam logic [AW:0] MARGIN_C    = (AW + 1)'(3);
    localparam logic [6:0]  MAX_BURST_C = 7'(MAX_BURST);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RD_OE    = 3'd1,
        S_RD_BURST = 3'd2,
        S_WR_BURST = 3'd3,
        S_TURN     = 3'd4
    } state_t;

    if (RX_BUF_DEPTH < 4 || (RX_BUF_DEPTH & (RX_BUF_DEPTH - 1)) != 0 ||
        MAX_BURST < 1 || MAX_BURST > 127 || SIWU_IDLE < 1) begin : g_bad_param
        $error("ft2232_fifo_arbiter: illegal parameter combination");
    end

    state_t          state_r;
    logic            rr_tx_r;
    logic [6:0]      burst_cnt_r;
    logic            oe_n_r;
    logic            rd_n_r;
    logic            wr_n_r;
    logic            data_oe_r;
    logic [7:0]      data_out_r;

    logic            hold_valid_r;
    logic [7:0]      hold_data_r;

    logic [7:0]      mem_r [RX_BUF_DEPTH];
    logic [AW-1:0]   wr_ptr_r;
    logic [AW-1:0]   rd_ptr_r;
    logic [AW:0]     count_r;

    logic            rx_push_s;
    logic            rx_pop_s;
    logic [AW:0]     free_s;
    logic            rx_req_s;
    logic            tx_req_s;
    logic            tx_consumed_s;
    logic            tx_load_s;
    logic            hold_valid_nxt_s;
    logic [7:0]      hold_data_nxt_s;
    logic            burst_inc_s;
    logic [6:0]      burst_plus_s;
    logic            burst_full_s;
    logic            rd_exit_s;
    logic            wr_exit_s;

    assign rx_valid_o       = ~reset_i & (count_r != {(AW + 1){1'b0}});
    assign rx_data_o        = mem_r[rd_ptr_r];
    assign rx_push_s        = ~reset_i & ~rd_n_r & ~fifo_rxf_n_i;
    assign rx_pop_s         = rx_valid_o & rx_ready_i;
    assign free_s           = DEPTH_C - count_r;
    assign rx_req_s         = ~fifo_rxf_n_i & (free_s >= MARGIN_C);

    assign tx_consumed_s    = ~wr_n_r & ~fifo_txe_n_i & (state_r == S_WR_BURST);
    assign tx_ready_o       = ~reset_i & (~hold_valid_r | tx_consumed_s);
    assign tx_load_s        = tx_valid_i & tx_ready_o;
    assign hold_valid_nxt_s = tx_load_s | (hold_valid_r & ~tx_consumed_s);
    assign hold_data_nxt_s  = tx_load_s ? tx_data_i : hold_data_r;
    assign tx_req_s         = hold_valid_r & ~fifo_txe_n_i;

    // Burst length including the transfer completing on this edge, so a burst stops at exactly MAX_BURST.
    always_comb begin
        burst_inc_s  = 1'b0;
        burst_plus_s = burst_cnt_r;
        if (state_r == S_RD_BURST) begin
            burst_inc_s = rx_push_s;
        end else if (state_r == S_WR_BURST) begin
            burst_inc_s = tx_consumed_s;
        end else begin
            burst_inc_s = 1'b0;
        end
        if (burst_inc_s && (burst_cnt_r != 7'h7F)) begin
            burst_plus_s = burst_cnt_r + 7'd1;
        end else begin
            burst_plus_s = burst_cnt_r;
        end
    end

    assign burst_full_s = (burst_plus_s >= MAX_BURST_C);
    assign rd_exit_s    = ~rx_req_s | (burst_full_s & tx_req_s);
    assign wr_exit_s    = fifo_txe_n_i | ~hold_valid_nxt_s | (burst_full_s & rx_req_s);

    // RX staging storage (no reset needed on the data array).
    always_ff @(posedge clk_i) begin
        if (rx_push_s) begin
            mem_r[wr_ptr_r] <= fifo_data_i;
        end
    end

    // RX staging pointers and occupancy.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW + 1){1'b0}};
        end else begin
            if (rx_push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1'b1);
            end
            if (rx_pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1'b1);
            end
            case ({rx_push_s, rx_pop_s})
                2'b10:   count_r <= count_r + (AW + 1)'(1'b1);
                2'b01:   count_r <= count_r - (AW + 1)'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

    // TX holding register; a byte is only released once the FT2232 actually took it.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            hold_valid_r <= 1'b0;
            hold_data_r  <= 8'h00;
        end else begin
            hold_valid_r <= hold_valid_nxt_s;
            hold_data_r  <= hold_data_nxt_s;
        end
    end

    // Bus FSM; pad strobes are registered together with the state they belong to.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r     <= S_IDLE;
            rr_tx_r     <= 1'b0;
            burst_cnt_r <= 7'd0;
            oe_n_r      <= 1'b1;
            rd_n_r      <= 1'b1;
            wr_n_r      <= 1'b1;
            data_oe_r   <= 1'b0;
            data_out_r  <= 8'h00;
        end else begin
            case (state_r)
                S_IDLE: begin
                    burst_cnt_r <= 7'd0;
                    if (rx_req_s && (!tx_req_s || !rr_tx_r)) begin
                        state_r <= S_RD_OE;
                        oe_n_r  <= 1'b0;
                    end else if (tx_req_s) begin
                        state_r    <= S_WR_BURST;
                        data_oe_r  <= 1'b1;
                        wr_n_r     <= 1'b0;
                        data_out_r <= hold_data_nxt_s;
                    end
                end
                S_RD_OE: begin
                    state_r <= S_RD_BURST;
                    rd_n_r  <= 1'b0;
                end
                S_RD_BURST: begin
                    burst_cnt_r <= burst_plus_s;
                    if (rd_exit_s) begin
                        state_r <= S_TURN;
                        oe_n_r  <= 1'b1;
                        rd_n_r  <= 1'b1;
                        rr_tx_r <= 1'b1;
                    end
                end
                S_WR_BURST: begin
                    burst_cnt_r <= burst_plus_s;
                    data_out_r  <= hold_data_nxt_s;
                    if (wr_exit_s) begin
                        state_r   <= S_IDLE;
                        data_oe_r <= 1'b0;
                        wr_n_r    <= 1'b1;
                        rr_tx_r   <= 1'b0;
                    end else begin
                        wr_n_r <= 1'b0;
                    end
                end
                S_TURN: begin
                    state_r <= S_IDLE;
                end
                default: begin
                    state_r   <= S_IDLE;
                    oe_n_r    <= 1'b1;
                    rd_n_r    <= 1'b1;
                    wr_n_r    <= 1'b1;
                    data_oe_r <= 1'b0;
                end
            endcase
        end
    end

    assign fifo_oe_n_o    = oe_n_r;
    assign fifo_rd_n_o    = rd_n_r;
    assign fifo_wr_n_o    = wr_n_r;
    assign fifo_data_oe_o = data_oe_r;
    assign fifo_data_o    = data_out_r;

`ifdef FIFO_SIWU_FLUSH_EN
    localparam int             SIWU_CW     = $clog2(SIWU_IDLE + 1);
    localparam logic [SIWU_CW-1:0] SIWU_IDLE_C = SIWU_CW'(SIWU_IDLE);

    logic               siwu_arm_r;
    logic [SIWU_CW-1:0] siwu_cnt_r;
    logic               siwu_r;

    // Counts quiet IDLE cycles after a TX burst drained the holding register, then pulses SIWU once.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            siwu_arm_r <= 1'b0;
            siwu_cnt_r <= {SIWU_CW{1'b0}};
            siwu_r     <= 1'b1;
        end else begin
            siwu_r <= 1'b1;
            if (state_r == S_WR_BURST) begin
                siwu_arm_r <= wr_exit_s & ~hold_valid_nxt_s;
                siwu_cnt_r <= {SIWU_CW{1'b0}};
            end else if (siwu_arm_r && (state_r == S_IDLE)) begin
                if (tx_valid_i) begin
                    siwu_cnt_r <= {SIWU_CW{1'b0}};
                end else if (siwu_cnt_r == SIWU_IDLE_C) begin
                    siwu_r     <= 1'b0;
                    siwu_arm_r <= 1'b0;
                end else begin
                    siwu_cnt_r <= siwu_cnt_r + SIWU_CW'(1'b1);
                end
            end
        end
    end

    assign fifo_siwu_o = siwu_r;
`else
    assign fifo_siwu_o = 1'b1;
`endif

endmodule

// File: tb/tb_ft2232_fifo_arbiter.sv
// Directed bench for ft2232_fifo_arbiter: host-side FT2232 model, upstream source and downstream sink.
module tb_ft2232_fifo_arbiter;

    localparam int SIWU_IDLE = 16;

    logic       clk_i = 1'b0;
    logic       reset_i;
    logic       fifo_rxf_n_i;
    logic       fifo_txe_n_i;
    logic [7:0] fifo_data_i;
    logic [7:0] fifo_data_o;
    logic       fifo_data_oe_o;
    logic       fifo_oe_n_o;
    logic       fifo_rd_n_o;
    logic       fifo_wr_n_o;
    logic       fifo_siwu_o;
    logic [7:0] rx_data_o;
    logic       rx_valid_o;
    logic       rx_ready_i;
    logic [7:0] tx_data_i;
    logic       tx_valid_i;
    logic       tx_ready_o;

    ft2232_fifo_arbiter #(
        .RX_BUF_DEPTH(8),
        .MAX_BURST(64),
        .SIWU_IDLE(SIWU_IDLE)
    ) dut (
        .clk_i(clk_i),
        .reset_i(reset_i),
        .fifo_rxf_n_i(fifo_rxf_n_i),
        .fifo_txe_n_i(fifo_txe_n_i),
        .fifo_data_i(fifo_data_i),
        .fifo_data_o(fifo_data_o),
        .fifo_data_oe_o(fifo_data_oe_o),
        .fifo_oe_n_o(fifo_oe_n_o),
        .fifo_rd_n_o(fifo_rd_n_o),
        .fifo_wr_n_o(fifo_wr_n_o),
        .fifo_siwu_o(fifo_siwu_o),
        .rx_data_o(rx_data_o),
        .rx_valid_o(rx_valid_o),
        .rx_ready_i(rx_ready_i),
        .tx_data_i(tx_data_i),
        .tx_valid_i(tx_valid_i),
        .tx_ready_o(tx_ready_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int failures = 0;

    logic [7:0] rx_src [256];
    logic [7:0] tx_src [256];
    logic [7:0] rx_got [256];
    logic [7:0] tx_got [256];
    int rx_total = 0, rx_idx = 0, rx_got_n = 0;
    int tx_total = 0, tx_sidx = 0, tx_got_n = 0;
    logic txe_manual = 1'b1;
    int stall_cnt = 0;
    logic stall_arm = 1'b0;

    int seg_len [16];
    logic seg_dir [16];
    int seg_n = 0;
    int drive_viol = 0, oe_only = 0, cnt_5a = 0, siwu_low = 0;
    int cyc = 0, wr_rise_cyc = 0, siwu_fall_cyc = 0;
    logic last_wr_n = 1'b1, last_siwu = 1'b1;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", tag, act, exp);
        end
    endtask

    task automatic drive_inputs();
        fifo_rxf_n_i = (rx_idx >= rx_total);
        fifo_data_i  = rx_src[rx_idx % 256];
        fifo_txe_n_i = txe_manual | (stall_cnt != 0);
        tx_valid_i   = (tx_sidx < tx_total);
        tx_data_i    = tx_src[tx_sidx % 256];
    endtask

    task automatic seg_add(input logic dir);
        if (seg_n == 0 || seg_dir[seg_n - 1] != dir) begin
            if (seg_n < 16) begin
                seg_dir[seg_n] = dir;
                seg_len[seg_n] = 0;
                seg_n++;
            end
        end
        if (seg_n > 0) seg_len[seg_n - 1]++;
    endtask

    // One clock: sample what the next rising edge will do, then update the models after the edge.
    task automatic tick();
        logic rd_take, wr_take, up_take, dn_take;
        logic [7:0] wr_byte, dn_byte;
        rd_take = !reset_i && !fifo_rd_n_o && !fifo_rxf_n_i;
        wr_take = !reset_i && !fifo_wr_n_o && !fifo_txe_n_i && fifo_data_oe_o;
        up_take = tx_valid_i && tx_ready_o;
        dn_take = rx_valid_o && rx_ready_i;
        wr_byte = fifo_data_o;
        dn_byte = rx_data_o;
        if (fifo_data_oe_o && !fifo_oe_n_o) drive_viol++;
        if (!fifo_oe_n_o && fifo_rd_n_o) oe_only++;
        if (fifo_data_oe_o && !fifo_wr_n_o && fifo_data_o == 8'h5A) cnt_5a++;
        if (!fifo_siwu_o) siwu_low++;
        if (fifo_wr_n_o && !last_wr_n) wr_rise_cyc = cyc;
        if (!fifo_siwu_o && last_siwu) siwu_fall_cyc = cyc;
        last_wr_n = fifo_wr_n_o;
        last_siwu = fifo_siwu_o;
        if (rd_take) seg_add(1'b0);
        if (wr_take) seg_add(1'b1);
        @(posedge clk_i);
        @(negedge clk_i);
        cyc++;
        if (rd_take) rx_idx++;
        if (wr_take && tx_got_n < 256) begin tx_got[tx_got_n] = wr_byte; tx_got_n++; end
        if (up_take) tx_sidx++;
        if (dn_take && rx_got_n < 256) begin rx_got[rx_got_n] = dn_byte; rx_got_n++; end
        if (stall_cnt > 0) stall_cnt--;
        else if (stall_arm && !fifo_wr_n_o && fifo_data_oe_o && fifo_data_o == 8'h5A) begin
            stall_cnt = 2;
            stall_arm = 1'b0;
        end
        drive_inputs();
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        reset_i    = 1'b1;
        rx_ready_i = 1'b0;
        drive_inputs();
        ticks(3);
        chk("rst_oe_n", fifo_oe_n_o, 1);
        chk("rst_rd_n", fifo_rd_n_o, 1);
        chk("rst_wr_n", fifo_wr_n_o, 1);
        chk("rst_siwu", fifo_siwu_o, 1);
        chk("rst_data_oe", fifo_data_oe_o, 0);
        chk("rst_data_o", fifo_data_o, 0);
        chk("rst_rx_valid", rx_valid_o, 0);
        chk("rst_tx_ready", tx_ready_o, 0);
        reset_i = 1'b0;
        ticks(2);

        // RX only: 10 bytes, sink always ready
        for (int i = 0; i < 256; i++) rx_src[i] = 8'(i);
        rx_total = 10; rx_idx = 0; rx_got_n = 0; rx_ready_i = 1'b1; oe_only = 0;
        drive_inputs();
        ticks(40);
        chk("rx_host_taken", rx_idx, 10);
        chk("rx_count", rx_got_n, 10);
        for (int i = 0; i < 10; i++) chk("rx_byte", rx_got[i], i);
        chk("rx_oe_lead_cycles", oe_only, 1);
        chk("rx_oe_released", fifo_oe_n_o, 1);

        // RX back-pressure: 20 bytes with sink stalled
        for (int i = 0; i < 256; i++) rx_src[i] = 8'(8'h40 + i);
        rx_total = 20; rx_idx = 0; rx_got_n = 0; rx_ready_i = 1'b0;
        drive_inputs();
        ticks(40);
        chk("bp_host_taken", rx_idx, 7);
        chk("bp_rd_n_high", fifo_rd_n_o, 1);
        chk("bp_rx_valid", rx_valid_o, 1);
        chk("bp_none_out", rx_got_n, 0);
        rx_ready_i = 1'b1;
        ticks(100);
        chk("bp_count", rx_got_n, 20);
        for (int i = 0; i < 20; i++) chk("bp_byte", rx_got[i], 8'h40 + i);

        // TX with a txe stall while the second byte is on the bus
        tx_src[0] = 8'hA5; tx_src[1] = 8'h5A; tx_src[2] = 8'h3C;
        tx_total = 3; tx_sidx = 0; tx_got_n = 0; txe_manual = 1'b0; stall_arm = 1'b1;
        cnt_5a = 0; drive_viol = 0;
        drive_inputs();
        ticks(30);
        chk("tx_count", tx_got_n, 3);
        chk("tx_byte0", tx_got[0], 8'hA5);
        chk("tx_byte1", tx_got[1], 8'h5A);
        chk("tx_byte2", tx_got[2], 8'h3C);
        chk("tx_5a_redriven", cnt_5a, 2);
        chk("tx_upstream_taken", tx_sidx, 3);
        chk("tx_drive_overlap", drive_viol, 0);

        // Single TX byte then idle: SIWU flush behaviour
        tx_src[0] = 8'h77; tx_total = 1; tx_sidx = 0; tx_got_n = 0; siwu_low = 0;
        drive_inputs();
        ticks(40);
        chk("siwu_tx_count", tx_got_n, 1);
        chk("siwu_tx_byte", tx_got[0], 8'h77);
`ifdef FIFO_SIWU_FLUSH_EN
        chk("siwu_pulses", siwu_low, 1);
        chk("siwu_delay", siwu_fall_cyc - wr_rise_cyc, SIWU_IDLE + 1);
`else
        chk("siwu_pulses", siwu_low, 0);
`endif

        // Reset in the middle of a read burst
        txe_manual = 1'b1;
        rx_total = 30; rx_idx = 0; rx_ready_i = 1'b1;
        drive_inputs();
        ticks(6);
        chk("mid_burst_active", fifo_rd_n_o, 0);
        reset_i = 1'b1;
        tick();
        chk("mid_rst_rd_n", fifo_rd_n_o, 1);
        chk("mid_rst_oe_n", fifo_oe_n_o, 1);
        chk("mid_rst_wr_n", fifo_wr_n_o, 1);
        chk("mid_rst_data_oe", fifo_data_oe_o, 0);
        chk("mid_rst_rx_valid", rx_valid_o, 0);
        ticks(2);
        rx_total = rx_idx;
        reset_i = 1'b0;
        drive_inputs();
        tick();
        chk("post_rst_rd_n", fifo_rd_n_o, 1);
        chk("post_rst_oe_n", fifo_oe_n_o, 1);
        chk("post_rst_rx_valid", rx_valid_o, 0);

        // Fairness: 200 bytes each way pending at the same time
        for (int i = 0; i < 256; i++) begin
            rx_src[i] = 8'(255 - i);
            tx_src[i] = 8'(3 * i + 1);
        end
        tx_total = 200; tx_sidx = 0; rx_total = 0; rx_idx = 0;
        drive_inputs();
        ticks(3);
        rx_total = 200; txe_manual = 1'b0;
        seg_n = 0; rx_got_n = 0; tx_got_n = 0; drive_viol = 0;
        drive_inputs();
        ticks(700);
        chk("fair_segments", seg_n, 8);
        for (int k = 0; k < 8; k++) begin
            chk("fair_seg_dir", seg_dir[k], k % 2);
            chk("fair_seg_len", seg_len[k], (k < 6) ? 64 : 8);
        end
        chk("fair_rx_count", rx_got_n, 200);
        chk("fair_tx_count", tx_got_n, 200);
        for (int i = 0; i < 200; i++) begin
            chk("fair_rx_byte", rx_got[i], 255 - i);
            chk("fair_tx_byte", tx_got[i], (3 * i + 1) % 256);
        end
        chk("fair_drive_overlap", drive_viol, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
